// File: rtl/soc_epoch_sequencer.sv
// soc_epoch_sequencer
// ---------------------------------------------------------------------------
// SoC-side controller for the CiM sleep-staging accelerator. Each epoch it:
//   1. announces a new epoch,
//   2. starts an EEG load,
//   3. streams NUM_SAMPLES ADC samples with at least SAMPLE_GAP idle cycles
//      after every strobe,
//   4. waits up to INFER_TIMEOUT cycles for the inference result and latches
//      the stage for the host.
// The accelerator is held in reset for CIM_RST_CYCLES when leaving IDLE. It is
// not reset again between back-to-back epochs.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   enable                   run epochs while high; sampled only in IDLE/NEXT
//   adc_valid/ready/data     ADC sample stream (handshake described below)
//   cim_rst_n                accelerator reset, active low
//   new_sleep_epoch          one-cycle epoch-start pulse
//   start_eeg_load           one-cycle load-start pulse
//   new_eeg_data, eeg        one-cycle sample strobe with its data
//   inference_complete       accelerator done (level or pulse)
//   inferred_sleep_stage     accelerator result
//   stage_valid, stage_out   one-cycle update pulse, last inferred stage
//   timeout_err              sticky inference-timeout flag
//   busy                     high whenever the FSM is not IDLE
//   dbg_state                current FSM state (debug observation only)
//
// Handshake: a sample transfers at a rising edge where adc_valid and
// adc_ready are both high. adc_ready is registered and never depends on
// adc_valid. A source that raises adc_valid must hold it and adc_data
// stable until the transfer, so no sample is ever dropped.
// ---------------------------------------------------------------------------
module soc_epoch_sequencer #(
  parameter int NUM_SAMPLES    = 3000,
  parameter int SAMPLE_GAP     = 4,
  parameter int CIM_RST_CYCLES = 8,
  parameter int INFER_TIMEOUT  = 1000000,
  parameter int ADC_W          = 16,
  parameter int STAGE_W        = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               adc_valid,
  input  logic [ADC_W-1:0]   adc_data,
  output logic               adc_ready,
  output logic               cim_rst_n,
  output logic               new_sleep_epoch,
  output logic               start_eeg_load,
  output logic               new_eeg_data,
  output logic [ADC_W-1:0]   eeg,
  input  logic               inference_complete,
  input  logic [STAGE_W-1:0] inferred_sleep_stage,
  output logic               stage_valid,
  output logic [STAGE_W-1:0] stage_out,
  output logic               timeout_err,
  output logic               busy,
  output logic [2:0]         dbg_state
);

  localparam int SCNT_W = $clog2(NUM_SAMPLES + 1);
  localparam int TCNT_W = $clog2(INFER_TIMEOUT + 1);
  localparam int GCNT_W = $clog2(SAMPLE_GAP + 1);
  localparam int RCNT_W = $clog2(CIM_RST_CYCLES + 1);

  localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(NUM_SAMPLES);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(INFER_TIMEOUT);
  localparam logic [GCNT_W-1:0] GAP_LEN  = GCNT_W'(SAMPLE_GAP);
  localparam logic [RCNT_W-1:0] RST_LAST = RCNT_W'(CIM_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_CIM_RST     = 3'd1,
    S_EPOCH_START = 3'd2,
    S_LOAD_START  = 3'd3,
    S_LOAD_WAIT   = 3'd4,
    S_INFER_WAIT  = 3'd5,
    S_NEXT        = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [RCNT_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [SCNT_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic [GCNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [TCNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [TCNT_W-1:0]   tmo_next;

  logic                adc_ready_q, adc_ready_d;
  logic                cim_rst_n_q, cim_rst_n_d;
  logic                new_sleep_epoch_q, new_sleep_epoch_d;
  logic                start_eeg_load_q, start_eeg_load_d;
  logic                new_eeg_data_q, new_eeg_data_d;
  logic [ADC_W-1:0]    eeg_q, eeg_d;
  logic                stage_valid_q, stage_valid_d;
  logic [STAGE_W-1:0]  stage_out_q, stage_out_d;
  logic                timeout_err_q, timeout_err_d;
  logic                busy_q, busy_d;

  always_comb begin
    state_d        = state_q;
    rst_cnt_d      = rst_cnt_q;
    sample_cnt_d   = sample_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    tmo_cnt_d      = tmo_cnt_q;
    tmo_next       = (tmo_cnt_q == TCNT_MAX) ? tmo_cnt_q : tmo_cnt_q + TCNT_W'(1);
    adc_ready_d    = 1'b0;
    new_eeg_data_d = 1'b0;
    eeg_d          = eeg_q;
    stage_valid_d  = 1'b0;
    stage_out_d    = stage_out_q;
    timeout_err_d  = timeout_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d   = S_CIM_RST;
          rst_cnt_d = '0;
        end
      end

      S_CIM_RST: begin
        if (rst_cnt_q == RST_LAST) state_d = S_EPOCH_START;
        else                       rst_cnt_d = rst_cnt_q + RCNT_W'(1);
      end

      S_EPOCH_START: state_d = S_LOAD_START;

      S_LOAD_START: begin
        state_d     = S_LOAD_WAIT;
        adc_ready_d = 1'b1;
        gap_cnt_d   = '0;
      end

      S_LOAD_WAIT: begin
        if (adc_ready_q && adc_valid) begin
          // Strobe next cycle and close the window for SAMPLE_GAP cycles
          // starting with the strobe cycle itself.
          new_eeg_data_d = 1'b1;
          eeg_d          = adc_data;
          gap_cnt_d      = GAP_LEN;
          if (sample_cnt_q != SCNT_MAX) sample_cnt_d = sample_cnt_q + SCNT_W'(1);
        end else if (sample_cnt_q == SCNT_MAX) begin
          // Current cycle carries the final strobe.
          state_d   = S_INFER_WAIT;
          tmo_cnt_d = '0;
        end else if (gap_cnt_q != '0) begin
          gap_cnt_d   = gap_cnt_q - GCNT_W'(1);
          adc_ready_d = (gap_cnt_q == GCNT_W'(1));
        end else begin
          adc_ready_d = 1'b1;
        end
      end

      S_INFER_WAIT: begin
        tmo_cnt_d = tmo_next;
        // A completion in the cycle the counter reaches the limit still wins.
        if (inference_complete) begin
          stage_out_d   = inferred_sleep_stage;
          stage_valid_d = 1'b1;
          state_d       = S_NEXT;
        end else if (tmo_next == TCNT_MAX) begin
          timeout_err_d = 1'b1;
          state_d       = S_NEXT;
        end
      end

      S_NEXT: state_d = enable ? S_EPOCH_START : S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Outputs that are a pure function of the state being entered.
    if (state_d == S_EPOCH_START) begin
      timeout_err_d = 1'b0;
      sample_cnt_d  = '0;
    end
    new_sleep_epoch_d = (state_d == S_EPOCH_START);
    start_eeg_load_d  = (state_d == S_LOAD_START);
    cim_rst_n_d       = !(state_d inside {S_IDLE, S_CIM_RST});
    busy_d            = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      rst_cnt_q         <= '0;
      sample_cnt_q      <= '0;
      gap_cnt_q         <= '0;
      tmo_cnt_q         <= '0;
      adc_ready_q       <= 1'b0;
      cim_rst_n_q       <= 1'b0;
      new_sleep_epoch_q <= 1'b0;
      start_eeg_load_q  <= 1'b0;
      new_eeg_data_q    <= 1'b0;
      eeg_q             <= '0;
      stage_valid_q     <= 1'b0;
      stage_out_q       <= '0;
      timeout_err_q     <= 1'b0;
      busy_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      rst_cnt_q         <= rst_cnt_d;
      sample_cnt_q      <= sample_cnt_d;
      gap_cnt_q         <= gap_cnt_d;
      tmo_cnt_q         <= tmo_cnt_d;
      adc_ready_q       <= adc_ready_d;
      cim_rst_n_q       <= cim_rst_n_d;
      new_sleep_epoch_q <= new_sleep_epoch_d;
      start_eeg_load_q  <= start_eeg_load_d;
      new_eeg_data_q    <= new_eeg_data_d;
      eeg_q             <= eeg_d;
      stage_valid_q     <= stage_valid_d;
      stage_out_q       <= stage_out_d;
      timeout_err_q     <= timeout_err_d;
      busy_q            <= busy_d;
    end
  end

  assign adc_ready       = adc_ready_q;
  assign cim_rst_n       = cim_rst_n_q;
  assign new_sleep_epoch = new_sleep_epoch_q;
  assign start_eeg_load  = start_eeg_load_q;
  assign new_eeg_data    = new_eeg_data_q;
  assign eeg             = eeg_q;
  assign stage_valid     = stage_valid_q;
  assign stage_out       = stage_out_q;
  assign timeout_err     = timeout_err_q;
  assign busy            = busy_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_soc_epoch_sequencer.sv
// Testbench for soc_epoch_sequencer (small parameter set).
// Directed epochs come from a vector table; reset-during-load is a hand
// sequence; the tail runs randomized epochs. Expected behaviour comes from
// epoch-level rules: samples come out in arrival order one cycle after their
// handshake, strobes are >= SAMPLE_GAP+1 apart, and a result arriving c
// cycles after the last strobe is accepted iff c <= INFER_TIMEOUT. Otherwise
// timeout_err rises INFER_TIMEOUT+1 cycles after the last strobe.
module tb_soc_epoch_sequencer;
  localparam int NS  = 4;
  localparam int GAP = 2;
  localparam int CRC = 3;
  localparam int TMO = 20;
  localparam int AW  = 16;
  localparam int SW  = 3;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          adc_valid;
  logic [AW-1:0] adc_data;
  logic          adc_ready;
  logic          cim_rst_n;
  logic          new_sleep_epoch;
  logic          start_eeg_load;
  logic          new_eeg_data;
  logic [AW-1:0] eeg;
  logic          inference_complete;
  logic [SW-1:0] inferred_sleep_stage;
  logic          stage_valid;
  logic [SW-1:0] stage_out;
  logic          timeout_err;
  logic          busy;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  soc_epoch_sequencer #(
    .NUM_SAMPLES(NS), .SAMPLE_GAP(GAP), .CIM_RST_CYCLES(CRC),
    .INFER_TIMEOUT(TMO), .ADC_W(AW), .STAGE_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .adc_valid(adc_valid), .adc_data(adc_data), .adc_ready(adc_ready),
    .cim_rst_n(cim_rst_n), .new_sleep_epoch(new_sleep_epoch),
    .start_eeg_load(start_eeg_load), .new_eeg_data(new_eeg_data), .eeg(eeg),
    .inference_complete(inference_complete),
    .inferred_sleep_stage(inferred_sleep_stage),
    .stage_valid(stage_valid), .stage_out(stage_out),
    .timeout_err(timeout_err), .busy(busy), .dbg_state(dbg_state)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [AW-1:0] exp_q[$];
  logic [SW-1:0] last_stage;

  typedef struct {
    bit            from_idle;
    int            vper;       // 0: random valid, else valid rises every vper cycles
    int            cdelay;     // cycles after last strobe that complete is driven
    logic [SW-1:0] stg;
    bit            drop;       // drop enable after first strobe
    bit            stray;      // stray inference_complete during load
    logic [AW-1:0] base;
    bit            exp_to;
    logic [SW-1:0] exp_stage;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cim_rst_n"}, int'(cim_rst_n), 0);
    check({tag, "_pulses"}, int'({new_sleep_epoch, start_eeg_load, new_eeg_data}), 0);
    check({tag, "_eeg"}, int'(eeg), 0);
    check({tag, "_adc_ready"}, int'(adc_ready), 0);
    check({tag, "_stage_out"}, int'(stage_out), 0);
    check({tag, "_stage_valid"}, int'(stage_valid), 0);
    check({tag, "_timeout_err"}, int'(timeout_err), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  // ---------------- driver + reference model for one epoch ----------------
  task automatic run_epoch(input vec_t v);
    int cyc, idx, strobes, last, n, ev;
    bit hs, accepted, want;

    inference_complete = 1'b0;
    if (v.from_idle) begin
      check("idle_busy", int'(busy), 0);
      check("idle_cim_rst_n", int'(cim_rst_n), 0);
      enable = 1'b1;
      n = 0;
      tick();
      while (busy && !cim_rst_n && n < 50) begin
        n++;
        tick();
      end
      check("cim_rst_len", n, CRC);
    end else begin
      tick();
    end

    // Epoch start cycle
    check("epoch_pulse", int'(new_sleep_epoch), 1);
    check("epoch_cim_rst_n", int'(cim_rst_n), 1);
    check("epoch_timeout_clr", int'(timeout_err), 0);
    check("epoch_quiet", int'({start_eeg_load, new_eeg_data, stage_valid, adc_ready}), 0);
    tick();
    check("load_pulse", int'(start_eeg_load), 1);
    check("load_quiet", int'({new_sleep_epoch, new_eeg_data, adc_ready}), 0);

    // Sample streaming
    cyc = 0; idx = 0; strobes = 0; last = 0;
    exp_q.delete();
    adc_valid = 1'b0;
    want = (v.vper == 0) ? ($urandom_range(0, 2) == 0) : 1'b1;
    if (want) begin
      adc_valid = 1'b1;
      adc_data  = v.base;
    end
    while (strobes < NS && cyc < 300) begin
      hs = adc_ready && adc_valid;
      if (hs) begin
        exp_q.push_back(adc_data);
        idx++;
      end
      tick();
      cyc++;
      check("strobe_vs_handshake", int'(new_eeg_data), int'(hs));
      if (new_eeg_data && hs) begin
        check("eeg_data", int'(eeg), int'(exp_q.pop_front()));
        if (strobes == 0 && v.vper == 1) check("first_strobe_cycle", cyc, 2);
        if (strobes > 0) begin
          check("strobe_gap_min", int'((cyc - last) >= GAP + 1), 1);
          if (v.vper == 1) check("strobe_gap_exact", cyc - last, GAP + 1);
        end
        strobes++;
        last = cyc;
        if (v.drop && strobes == 1) enable = 1'b0;
      end
      check("load_no_other_pulse", int'({new_sleep_epoch, start_eeg_load, stage_valid}), 0);
      check("load_busy", int'(busy), 1);
      // Source: valid stays up until consumed, data held with it.
      if (hs) adc_valid = 1'b0;
      if (v.vper == 0) want = ($urandom_range(0, 2) == 0);
      else             want = ((cyc % v.vper) == 0);
      if (!adc_valid && idx < NS && want) begin
        adc_valid = 1'b1;
        adc_data  = v.base + AW'(idx);
      end
      inference_complete   = v.stray ? ($urandom_range(0, 3) == 0) : 1'b0;
      inferred_sleep_stage = SW'($urandom);
    end
    check("strobe_count", strobes, NS);
    check("samples_offered", idx, NS);

    // Inference wait: current cycle is the final strobe cycle.
    adc_valid          = 1'b0;
    inference_complete = 1'b0;
    accepted = (v.cdelay <= TMO);
    ev       = accepted ? v.cdelay + 1 : TMO + 1;
    for (int k = 1; k <= ev; k++) begin
      tick();
      check("stage_valid", int'(stage_valid), int'(accepted && k == ev));
      check("timeout_err", int'(timeout_err), int'(!accepted && k == ev));
      check("stage_out", int'(stage_out), int'((accepted && k == ev) ? v.stg : last_stage));
      check("infer_quiet", int'({adc_ready, new_eeg_data, new_sleep_epoch, start_eeg_load}), 0);
      check("infer_busy", int'(busy), 1);
      inference_complete   = (k == v.cdelay);
      inferred_sleep_stage = (k == v.cdelay) ? v.stg : SW'($urandom);
    end
    if (accepted) last_stage = v.stg;
    inference_complete = 1'b0;

    if (v.drop) begin
      tick();
      check("end_idle_busy", int'(busy), 0);
      check("end_idle_cim_rst_n", int'(cim_rst_n), 0);
      check("end_idle_quiet", int'({stage_valid, new_sleep_epoch, adc_ready}), 0);
    end
  endtask

  task automatic run_and_check(input vec_t v, input string tag);
    run_epoch(v);
    check({tag, "_final_timeout_err"}, int'(timeout_err), int'(v.exp_to));
    check({tag, "_final_stage_out"}, int'(stage_out), int'(v.exp_stage));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   cnt, n;
    vec_t rv;

    rst = 1'b1; enable = 1'b0; adc_valid = 1'b0; adc_data = '0;
    inference_complete = 1'b0; inferred_sleep_stage = '0;
    last_stage = '0;

    //        idle vper cd   stg   drop stray base      exp_to exp_stage
    vecs[0] = '{1'b1, 1, 5,  3'd3, 1'b0, 1'b0, 16'h0011, 1'b0, 3'd3};
    vecs[1] = '{1'b0, 5, 2,  3'd6, 1'b0, 1'b0, 16'h0021, 1'b0, 3'd6};
    vecs[2] = '{1'b0, 1, 99, 3'd0, 1'b0, 1'b0, 16'h0031, 1'b1, 3'd6};
    vecs[3] = '{1'b0, 2, 20, 3'd5, 1'b0, 1'b0, 16'h0041, 1'b0, 3'd5};
    vecs[4] = '{1'b0, 3, 21, 3'd1, 1'b0, 1'b1, 16'h0051, 1'b1, 3'd5};
    vecs[5] = '{1'b0, 1, 1,  3'd7, 1'b1, 1'b0, 16'h0061, 1'b0, 3'd7};

    tick(); tick(); tick();
    check_reset("reset");
    rst = 1'b0;
    tick();
    check("post_reset_idle", int'(busy), 0);

    for (int i = 0; i < 6; i++) run_and_check(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of loading: everything returns to reset values.
    enable = 1'b1; adc_valid = 1'b1; adc_data = 16'h00A0;
    cnt = 0; n = 0;
    while (cnt < 2 && n < 100) begin
      tick();
      n++;
      if (new_eeg_data) cnt++;
    end
    check("pre_reset_strobes", cnt, 2);
    rst = 1'b1;
    tick();
    check_reset("midload_reset");
    rst = 1'b0; enable = 1'b0; adc_valid = 1'b0;
    last_stage = '0;
    tick();
    check("post_midload_idle", int'(busy), 0);

    rv = '{1'b1, 1, 3, 3'd2, 1'b0, 1'b0, 16'h0100, 1'b0, 3'd2};
    run_and_check(rv, "restart");

    // Randomized back-to-back epochs
    for (int r = 0; r < 8; r++) begin
      rv.from_idle = 1'b0;
      rv.vper      = $urandom_range(0, 4);
      rv.cdelay    = $urandom_range(1, TMO + 2);
      rv.stg       = SW'($urandom);
      rv.drop      = (r == 7);
      rv.stray     = 1'b1;
      rv.base      = AW'($urandom);
      rv.exp_to    = (rv.cdelay > TMO);
      rv.exp_stage = (rv.cdelay <= TMO) ? rv.stg : last_stage;
      run_and_check(rv, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
